// File: rtl/audio_i2s_tx_if.sv
// rtl/audio_i2s_tx_if.sv - sample-pair handshake bundle for audio_i2s_tx
//
// Purpose: groups the stereo sample pair with its valid/ready handshake.
// Signals:
//   sample_l     [15:0] left sample, two's complement
//   sample_r     [15:0] right sample, two's complement
//   sample_valid        source offers a pair
//   sample_ready        sink holding buffer empty
// Modports: master = sample source, slave = audio_i2s_tx.
`timescale 1ns/1ps
interface audio_i2s_tx_if;
  logic [15:0] sample_l;
  logic [15:0] sample_r;
  logic        sample_valid;
  logic        sample_ready;

  modport master (output sample_l, output sample_r, output sample_valid, input  sample_ready);
  modport slave  (input  sample_l, input  sample_r, input  sample_valid, output sample_ready);
endinterface

// File: rtl/audio_i2s_tx.sv
// rtl/audio_i2s_tx.sv - I2S stereo transmitter with one-pair holding buffer
//
// Purpose: serialises 16-bit stereo pairs as 32-bit I2S frames (MSB first,
// one BCLK delay after the word-select edge). A single-entry holding buffer
// decouples the sample source from the frame boundary.
// Parameters: BCLK_DIV - clk cycles per AUD_BCLK half-period (1..255).
// Ports:
//   clk, resetN    system clock, asynchronous active-low reset
//   en             run enable; dropping it ends transmission after the frame
//   smp            sample pair handshake (audio_i2s_tx_if.slave)
//   AUD_BCLK       bit clock
//   AUD_DACLRCK    word select, 0 = left, 1 = right
//   AUD_DACDAT     serial data, changes only on BCLK falling ticks
//   underrun       one-clk pulse when a frame starts with the buffer empty
//   underrun_cnt   saturating underrun count (AUDIO_I2S_TX_UNDERRUN_CNT_EN only)
// Build option: AUDIO_I2S_TX_UNDERRUN_CNT_EN adds underrun_cnt.
`timescale 1ns/1ps
module audio_i2s_tx #(
  parameter int unsigned BCLK_DIV = 4
) (
  input  logic           clk,
  input  logic           resetN,
  input  logic           en,
  audio_i2s_tx_if.slave  smp,
  output logic           AUD_BCLK,
  output logic           AUD_DACLRCK,
  output logic           AUD_DACDAT,
  output logic           underrun
`ifdef AUDIO_I2S_TX_UNDERRUN_CNT_EN
  ,
  output logic [7:0]     underrun_cnt
`endif
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [7:0] DIV_LAST = 8'(BCLK_DIV - 1);

  state_t      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic        bclk_q, bclk_d;
  logic [4:0]  bit_q, bit_d;
  logic        lrck_q, lrck_d;
  logic        dat_q, dat_d;
  logic [31:0] frame_q, frame_d;
  logic [31:0] hold_q, hold_d;
  logic        full_q, full_d;
  logic        underrun_q, underrun_d;

  logic        accept;
  logic        div_wrap;
  logic        fall_tick;
  logic        frame_load;
  logic [4:0]  bit_inc;
  logic [31:0] incoming;

  assign incoming  = {smp.sample_l, smp.sample_r};
  assign accept    = smp.sample_valid & ~full_q;
  assign div_wrap  = (div_q == DIV_LAST);
  assign fall_tick = (state_q == RUN) && div_wrap && bclk_q;
  assign bit_inc   = bit_q + 5'd1;

  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    bclk_d     = bclk_q;
    bit_d      = bit_q;
    lrck_d     = lrck_q;
    dat_d      = dat_q;
    frame_d    = frame_q;
    hold_d     = hold_q;
    full_d     = full_q;
    underrun_d = 1'b0;
    frame_load = 1'b0;

    case (state_q)
      IDLE: begin
        div_d  = 8'd0;
        bclk_d = 1'b0;
        bit_d  = 5'd0;
        lrck_d = 1'b0;
        dat_d  = 1'b0;
        if (en) begin
          state_d    = RUN;
          frame_load = 1'b1;
        end
      end
      RUN: begin
        if (div_wrap) begin
          div_d  = 8'd0;
          bclk_d = ~bclk_q;
        end else begin
          div_d = div_q + 8'd1;
        end
        if (fall_tick) begin
          bit_d  = bit_inc;
          lrck_d = bit_inc[4];
          // Bit k shows frame bit k-1; at k=0 that is the outgoing frame's R[0],
          // taken from frame_q before this edge's reload.
          dat_d  = frame_q[~bit_q];
          if (bit_q == 5'd31) begin
            if (!en) begin
              // Stop cleanly at the frame boundary; no new frame starts.
              state_d = IDLE;
              lrck_d  = 1'b0;
              dat_d   = 1'b0;
            end else begin
              frame_load = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (frame_load) begin
      if (full_q) begin
        frame_d = hold_q;
        if (accept) hold_d = incoming;
        full_d = accept;
      end else if (accept) begin
        // Empty buffer: the incoming pair bypasses straight into the frame.
        frame_d = incoming;
      end else begin
        // Nothing new: repeat the last frame and flag the underrun.
        underrun_d = 1'b1;
      end
    end else if (accept) begin
      hold_d = incoming;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q    <= IDLE;
      div_q      <= 8'd0;
      bclk_q     <= 1'b0;
      bit_q      <= 5'd0;
      lrck_q     <= 1'b0;
      dat_q      <= 1'b0;
      frame_q    <= 32'd0;
      hold_q     <= 32'd0;
      full_q     <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      bclk_q     <= bclk_d;
      bit_q      <= bit_d;
      lrck_q     <= lrck_d;
      dat_q      <= dat_d;
      frame_q    <= frame_d;
      hold_q     <= hold_d;
      full_q     <= full_d;
      underrun_q <= underrun_d;
    end
  end

  assign smp.sample_ready = ~full_q;
  assign AUD_BCLK         = bclk_q;
  assign AUD_DACLRCK      = lrck_q;
  assign AUD_DACDAT       = dat_q;
  assign underrun         = underrun_q;

`ifdef AUDIO_I2S_TX_UNDERRUN_CNT_EN
  logic [7:0] ucnt_q, ucnt_d;

  always_comb begin
    ucnt_d = ucnt_q;
    if (underrun_d && (ucnt_q != 8'hFF)) ucnt_d = ucnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) ucnt_q <= 8'd0;
    else         ucnt_q <= ucnt_d;
  end

  assign underrun_cnt = ucnt_q;
`endif

endmodule
